// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between two byte-stream requesters.
//   ch0 = memory dump stream, ch1 = status/acknowledge responder.
// Arbitration is round-robin per packet, so frames from the two channels
// never interleave on the transmitter.
// Optional build macro: UART_TX_ARB_LOCK_TIMEOUT_EN releases a lock whose
// owner has stopped presenting bytes for LOCK_TIMEOUT idle cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | pick a channel; grant when uart_tx is ready
// ISSUE      | one-cycle start pulse to uart_tx
// WAIT_BUSY  | wait for uart_tx to drop ready (bounded by BUSY_WAIT)
// WAIT_READY | wait for uart_tx to finish the byte
module uart_tx_arbiter #(
  parameter int DATA_SIZE    = 8,
  parameter int BUSY_WAIT    = 16,
  parameter int CNT_SIZE     = 5,
  parameter int LOCK_TIMEOUT = 31
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_req0_valid,
  input  logic [DATA_SIZE-1:0] i_req0_data,
  input  logic                 i_req0_last,
  output logic                 o_req0_ack,
  input  logic                 i_req1_valid,
  input  logic [DATA_SIZE-1:0] i_req1_data,
  input  logic                 i_req1_last,
  output logic                 o_req1_ack,
  input  logic                 i_tx_ready,
  output logic                 o_tx_start,
  output logic [DATA_SIZE-1:0] o_tx_data,
  output logic                 o_owner,
  output logic                 o_locked,
  output logic                 o_busy,
  output logic                 o_tx_error,
  output logic                 o_lock_timeout
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_BUSY  = 2'd2,
    WAIT_READY = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_SIZE-1:0]  r_cnt;
  logic [DATA_SIZE-1:0] r_tx_data;
  logic                 r_owner;
  logic                 r_locked;
  // Channel that finished the most recent packet; the other one wins ties.
  logic                 r_rr_last;

  logic                 w_elig0;
  logic                 w_elig1;
  logic                 w_sel;
  logic                 w_sel_last;
  logic [DATA_SIZE-1:0] w_sel_data;
  logic                 w_grant;
  logic                 w_tx_start;
  logic                 w_tx_error;
  logic                 w_ack0;
  logic                 w_ack1;
  logic                 w_lock_to;

  // Candidate selection: a lock restricts eligibility to the owner.
  always_comb begin
    w_elig0    = i_req0_valid & (~r_locked | ~r_owner);
    w_elig1    = i_req1_valid & (~r_locked |  r_owner);
    w_sel      = (w_elig0 & w_elig1) ? ~r_rr_last : w_elig1;
    w_sel_last = w_sel ? i_req1_last : i_req0_last;
    w_sel_data = w_sel ? i_req1_data : i_req0_data;
    w_grant    = (r_state == IDLE) & ~i_reset & i_tx_ready & (w_elig0 | w_elig1);
  end

  // Next-state and pulse outputs; nothing pulses while reset is held.
  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    w_tx_error = 1'b0;
    w_ack0     = 1'b0;
    w_ack1     = 1'b0;
    if (!i_reset) begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            w_ack0 = ~w_sel;
            w_ack1 = w_sel;
            w_next = ISSUE;
          end
        end
        ISSUE: begin
          w_tx_start = 1'b1;
          w_next     = WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!i_tx_ready) begin
            w_next = WAIT_READY;
          end else if (r_cnt == CNT_SIZE'(BUSY_WAIT)) begin
            w_tx_error = 1'b1;
            w_next     = IDLE;
          end
        end
        WAIT_READY: begin
          if (i_tx_ready) w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Busy-wait counter: cleared on start, counts cycles uart_tx stays ready.
  always_ff @(posedge i_clock) begin
    if (i_reset)                                      r_cnt <= '0;
    else if (r_state == ISSUE)                        r_cnt <= '0;
    else if ((r_state == WAIT_BUSY) && i_tx_ready)    r_cnt <= r_cnt + 1'b1;
  end

  // Grant bookkeeping: data latch, owner, packet lock and rr pointer.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_data <= '0;
      r_owner   <= 1'b0;
      r_locked  <= 1'b0;
      r_rr_last <= 1'b1;
    end else if (w_grant) begin
      r_tx_data <= w_sel_data;
      r_owner   <= w_sel;
      r_locked  <= ~w_sel_last;
      if (w_sel_last) r_rr_last <= w_sel;
    end else if (w_lock_to) begin
      // Point rr at the stalled owner so the other channel wins next.
      r_locked  <= 1'b0;
      r_rr_last <= r_owner;
    end
  end

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
  logic [CNT_SIZE-1:0] r_lock_cnt;
  logic                w_owner_valid;

  assign w_owner_valid = r_owner ? i_req1_valid : i_req0_valid;
  assign w_lock_to     = ~i_reset & (r_state == IDLE) & r_locked & ~w_owner_valid &
                         (r_lock_cnt == CNT_SIZE'(LOCK_TIMEOUT));

  // Counts idle cycles spent waiting on a silent lock owner.
  always_ff @(posedge i_clock) begin
    if (i_reset)                                   r_lock_cnt <= '0;
    else if (w_lock_to || !r_locked || w_owner_valid) r_lock_cnt <= '0;
    else if (r_state == IDLE)                      r_lock_cnt <= r_lock_cnt + 1'b1;
  end
`else
  // LOCK_TIMEOUT only matters when the timeout logic is built in.
  logic w_unused_lock_timeout;
  assign w_unused_lock_timeout = (LOCK_TIMEOUT > 0);
  assign w_lock_to             = 1'b0;
`endif

  assign o_req0_ack     = w_ack0;
  assign o_req1_ack     = w_ack1;
  assign o_tx_start     = w_tx_start;
  assign o_tx_error     = w_tx_error;
  assign o_tx_data      = r_tx_data;
  assign o_owner        = r_owner;
  assign o_locked       = r_locked;
  assign o_busy         = (r_state != IDLE);
  assign o_lock_timeout = w_lock_to;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_tx transmitter between two byte-stream requesters.
- ch0: dump_unit memory dump.
- ch1: status/acknowledge responder answering command_unit traffic.
Arbitration is round-robin at packet granularity, so dump frames and response frames never interleave on o_tx. Sits between the requesters and u_uart_tx in the system clock domain.

Parameters:
DATA_SIZE, 8, byte width on all data ports (matches UART_DATA_SIZE).
BUSY_WAIT, 16, max cycles to wait for i_tx_ready to fall after a start pulse.
CNT_SIZE, 5, width of the busy-wait counter and the lock-timeout counter; must hold BUSY_WAIT and LOCK_TIMEOUT.
LOCK_TIMEOUT, 31, idle cycles before a stalled locked owner is released (used only with the optional feature).

Ports:
i_clock  in  1  system clock (sys_clock)
i_reset  in  1  synchronous active-high reset (sys_reset)
i_req0_valid  in  1  ch0 byte available
i_req0_data  in  DATA_SIZE  ch0 byte
i_req0_last  in  1  ch0 byte is last of its packet
o_req0_ack  out  1  one-cycle pulse: ch0 byte consumed
i_req1_valid  in  1  ch1 byte available
i_req1_data  in  DATA_SIZE  ch1 byte
i_req1_last  in  1  ch1 byte is last of its packet
o_req1_ack  out  1  one-cycle pulse: ch1 byte consumed
i_tx_ready  in  1  uart_tx ready
o_tx_start  out  1  start pulse to uart_tx
o_tx_data  out  DATA_SIZE  byte to uart_tx
o_owner  out  1  current/last granted channel
o_locked  out  1  a packet is in progress; owner fixed
o_busy  out  1  state != IDLE
o_tx_error  out  1  one-cycle pulse: uart_tx never went busy after start
o_lock_timeout  out  1  one-cycle pulse: lock forcibly released

Behaviour:
- Reset: synchronous, all outputs 0; state IDLE; lock cleared; rr pointer set so ch0 wins the first tie. Reset mid-transfer abandons the in-flight byte with no retry and no ack re-issue.
- Requester rule: hold valid/data/last stable until ack; ack consumes exactly one byte.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_READY.
- IDLE, candidate selection:
  - If locked, only the owner is eligible.
  - Else eligible = valid channels; if both are valid, grant the channel not served last (rr).
- IDLE, grant (eligible channel exists and i_tx_ready=1), same cycle:
  - Latch data into o_tx_data.
  - Pulse that channel's ack.
  - Set o_owner.
  - o_locked <= ~last.
  - Go to ISSUE.
- ISSUE: o_tx_start=1 for exactly one cycle; clear counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - i_tx_ready=0: go to WAIT_READY.
  - Counter reaches BUSY_WAIT first: pulse o_tx_error, go to IDLE. Lock state is unchanged.
- WAIT_READY: i_tx_ready=1 -> IDLE.
- Latency: valid with tx ready -> ack same cycle -> o_tx_start next cycle.
- o_tx_data is held stable from latch until the next grant.
- rr pointer updates only when the granted byte has last=1, i.e. at packet end.
- Single-byte packet (last=1 on the first byte): never locks.
- While locked, the non-owner is starved regardless of its valid.
- Simultaneous valid on both channels with lock clear: exactly one ack, never both.
- At most one ack asserted in any cycle.

Optional Feature:
Macro UART_TX_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - In IDLE with o_locked=1 and owner valid=0, a counter increments each cycle; it resets on owner valid.
  - At LOCK_TIMEOUT: clear lock, pulse o_lock_timeout, next arbitration is free round-robin with rr pointing away from the stalled owner.
- Undefined: lock held indefinitely; o_lock_timeout tied 0; no counter logic.

Test Plan:
1. Single byte: after reset, ch0 valid, data 0x5A, last=1, tx_ready=1 -> ack0 same cycle, o_tx_start next cycle with o_tx_data=0x5A, o_locked stays 0.
2. Tie: both channels valid with last=1 (0x11 / 0x22), model uart busy 4 cycles per byte -> bytes emitted 0x11, 0x22, 0x11, 0x22 alternating.
3. Packet lock: ch0 sends 3-byte packet A1, A2, A3 (last on A3) while ch1 holds 0xB0 valid throughout -> o_tx order A1, A2, A3, B0; ack1 low until A3 acked.
4. Stuck transmitter: tx_ready stays 1 after start -> o_tx_error pulse exactly BUSY_WAIT+1 cycles after o_tx_start, state returns to IDLE.
5. Reset mid-packet: assert i_reset in WAIT_READY with lock set -> next cycle all outputs 0, o_locked=0, ch0 granted first afterwards.
6. With UART_TX_ARB_LOCK_TIMEOUT_EN: ch1 sends first byte (last=0), then drops valid, ch0 valid -> o_lock_timeout after 31 idle cycles, ch0 granted in the following cycle. Without the macro: ch0 is never granted.
